debug_streamer: RTL and testbench

DEBUG_STREAMER -- requirements
Module: debug_streamer

---
 rtl/debug_streamer.sv | 107 ++++++++++
 tb/tb_debug_streamer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_streamer.sv
// Debug snapshot streamer: on a host request or halt rising edge, captures a
// snapshot and emits HEADER, the snapshot bytes LSB first, then a mod-256 checksum.
module debug_streamer #(
  parameter int         SNAP_BYTES = 184,
  parameter logic [7:0] HEADER     = 8'hA5,
  parameter bit         AUTO_HALT  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SNAP_BYTES*8-1:0] snap_in,
  input  logic                    halt,
  input  logic                    req,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    overrun,
  output logic [7:0]              frame_cnt
);

  localparam int IDX_W = (SNAP_BYTES > 1) ? $clog2(SNAP_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SNAP_BYTES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_DATA, ST_CKSUM} state_t;

  state_t                  state, state_nxt;
  logic [SNAP_BYTES*8-1:0] shadow;
  logic [SNAP_BYTES*8-1:0] shifted;
  logic [IDX_W-1:0]        idx;
  logic [7:0]              cksum;
  logic [7:0]              data_byte;
  logic                    halt_q;
  logic                    trigger;
  logic                    hs;

  always_comb begin
    trigger   = req | (AUTO_HALT & halt & ~halt_q);
    shifted   = shadow >> {idx, 3'b000};
    data_byte = shifted[7:0];
    out_valid = (state != ST_IDLE);
    busy      = (state != ST_IDLE);
    hs        = out_valid & out_ready;
  end

  // Output byte is decoded from registered state only, so out_ready never reaches out_valid.
  always_comb begin
    out_data = '0;
    case (state)
      ST_HEADER: out_data = HEADER;
      ST_DATA:   out_data = data_byte;
      ST_CKSUM:  out_data = cksum;
      default:   out_data = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (trigger) state_nxt = ST_HEADER;
      ST_HEADER: if (hs) state_nxt = ST_DATA;
      ST_DATA:   if (hs && (idx == LAST_IDX)) state_nxt = ST_CKSUM;
      ST_CKSUM:  if (hs) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow    <= '0;
      idx       <= '0;
      cksum     <= '0;
      halt_q    <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      halt_q <= halt;
      if ((state != ST_IDLE) && trigger) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            shadow <= snap_in;
            cksum  <= '0;
          end
        end
        ST_HEADER: begin
          if (hs) idx <= '0;
        end
        ST_DATA: begin
          if (hs) begin
            cksum <= cksum + data_byte;
            if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
          end
        end
        ST_CKSUM: begin
          if (hs) frame_cnt <= frame_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_streamer.sv
// Directed/randomized bench for debug_streamer; expected frames come from a
// byte-list reference model (header, snapshot bytes, modular sum).
module tb_debug_streamer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] snap_in;
  logic        halt, req, out_ready;
  logic [7:0]  out_data;
  logic        out_valid, busy, overrun;
  logic [7:0]  frame_cnt;

  logic [7:0]  snap1;
  logic        req1, ready1;
  logic [7:0]  out_data1;
  logic        out_valid1, busy1, overrun1;
  logic [7:0]  frame_cnt1;

  debug_streamer #(.SNAP_BYTES(4), .HEADER(8'hA5), .AUTO_HALT(1'b1)) dut (
    .clk(clk), .reset(reset), .snap_in(snap_in), .halt(halt), .req(req),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .overrun(overrun), .frame_cnt(frame_cnt)
  );

  debug_streamer #(.SNAP_BYTES(1), .HEADER(8'hA5), .AUTO_HALT(1'b0)) dut1 (
    .clk(clk), .reset(reset), .snap_in(snap1), .halt(halt), .req(req1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(ready1),
    .busy(busy1), .overrun(overrun1), .frame_cnt(frame_cnt1)
  );

  int          tests = 0;
  int          fails = 0;
  logic        s_valid = 1'b0, s_ready = 1'b0, s_busy = 1'b0, s_reset = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s1_valid = 1'b0, s1_busy = 1'b0, seen1_busy = 1'b0;
  logic [7:0]  s1_data = '0;
  logic [7:0]  got[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: header, snapshot bytes LSB first, then their sum mod 256.
  function automatic void build_frame(input logic [31:0] s);
    int sum;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'((s >> (8 * i)) & 32'hFF));
      sum = (sum + int'((s >> (8 * i)) & 32'hFF)) % 256;
    end
    exp_q.push_back(8'(sum));
  endfunction

  // Sample at the falling edge; inputs only change just after the rising edge.
  task automatic tick();
    logic pv, pr, pres;
    logic [7:0] pd;
    pv = s_valid; pr = s_ready; pd = s_data; pres = s_reset;
    @(negedge clk);
    s_valid = out_valid; s_data = out_data; s_busy = busy;
    s_ready = out_ready; s_reset = reset;
    s1_valid = out_valid1; s1_data = out_data1; s1_busy = busy1;
    if (busy1) seen1_busy = 1'b1;
    if (pres && reset && pv && !pr) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data", {24'd0, out_data}, {24'd0, pd});
    end
    if (reset && out_valid && out_ready) got.push_back(out_data);
    @(posedge clk);
    #1;
  endtask

  task automatic finish_frame(input bit rnd, input int limit);
    int n;
    n = 0;
    do begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end while (s_busy && n < limit);
    check("frame_timeout", {31'd0, (n < limit)}, 32'd1);
  endtask

  task automatic run_frame(input bit rnd, input int limit);
    got.delete();
    req = 1'b1;
    tick();
    req = 1'b0;
    finish_frame(rnd, limit);
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got.size())
        check($sformatf("%s[%0d]", tag, i), {24'd0, got[i]}, {24'd0, exp_q[i]});
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; req = 1'b0; out_ready = 1'b1; snap_in = '0;
    snap1 = 8'h3C; req1 = 1'b0; ready1 = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // Basic frame, one byte per cycle starting the cycle after req.
    snap_in = 32'h04030201;
    build_frame(snap_in);
    got.delete();
    req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("basic_valid[%0d]", i), {31'd0, s_valid}, 32'd1);
      check($sformatf("basic_byte[%0d]", i), {24'd0, s_data}, {24'd0, exp_q[i]});
    end
    tick();
    check("basic_busy_after", {31'd0, s_busy}, 32'd0);
    check("basic_frame_cnt", {24'd0, frame_cnt}, 32'd1);
    check("basic_overrun", {31'd0, overrun}, 32'd0);
    exp_cnt = 8'd1;

    // Backpressure with random snapshots and random out_ready.
    for (int k = 0; k < 3; k++) begin
      snap_in = $urandom;
      build_frame(snap_in);
      run_frame(1'b1, 300);
      compare_frame("bp");
      exp_cnt = exp_cnt + 8'd1;
      check("bp_frame_cnt", {24'd0, frame_cnt}, {24'd0, exp_cnt});
    end
    out_ready = 1'b1;

    // SNAP_BYTES=1 instance: header, single byte, checksum.
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    tick();
    check("one_hdr", {23'd0, s1_valid, s1_data}, {23'd0, 1'b1, 8'hA5});
    tick();
    check("one_data", {23'd0, s1_valid, s1_data}, {23'd0, 1'b1, 8'h3C});
    tick();
    check("one_cksum", {23'd0, s1_valid, s1_data}, {23'd0, 1'b1, 8'h3C});
    tick();
    check("one_busy_after", {31'd0, s1_busy}, 32'd0);
    check("one_frame_cnt", {24'd0, frame_cnt1}, 32'd1);

    // Overrun and capture isolation: req and snapshot change mid-frame.
    check("ovr_before", {31'd0, overrun}, 32'd0);
    snap_in = 32'h04030201;
    build_frame(snap_in);
    got.delete();
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    tick();
    req = 1'b1;
    snap_in = 32'hFFFFFFFF;
    tick();
    req = 1'b0;
    finish_frame(1'b0, 20);
    compare_frame("ovr");
    repeat (3) tick();
    check("ovr_idle", {31'd0, s_busy}, 32'd0);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    exp_cnt = exp_cnt + 8'd1;
    check("ovr_frame_cnt", {24'd0, frame_cnt}, {24'd0, exp_cnt});

    // Halt held high: one frame here, none on the request-only instance.
    build_frame(snap_in);
    got.delete();
    seen1_busy = 1'b0;
    halt = 1'b1;
    repeat (20) tick();
    halt = 1'b0;
    repeat (5) tick();
    compare_frame("halt");
    exp_cnt = exp_cnt + 8'd1;
    check("halt_frame_cnt", {24'd0, frame_cnt}, {24'd0, exp_cnt});
    check("halt_no_busy1", {31'd0, seen1_busy}, 32'd0);
    check("halt_cnt1", {24'd0, frame_cnt1}, 32'd1);
    check("halt_overrun1", {31'd0, overrun1}, 32'd0);

    // Reset mid-frame clears outputs without a clock edge.
    snap_in = 32'h04030201;
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    s_reset = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_overrun", {31'd0, overrun}, 32'd0);
    check("mid_rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    check("mid_rst_data", {24'd0, out_data}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    snap_in = $urandom;
    build_frame(snap_in);
    run_frame(1'b0, 20);
    compare_frame("post_rst");
    check("post_rst_frame_cnt", {24'd0, frame_cnt}, 32'd1);

    // Halt already high at the first edge after reset release triggers a frame.
    reset = 1'b0;
    s_reset = 1'b0;
    halt = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    build_frame(snap_in);
    got.delete();
    tick();
    tick();
    check("halt_rel_hdr", {23'd0, s_valid, s_data}, {23'd0, 1'b1, 8'hA5});
    finish_frame(1'b0, 20);
    halt = 1'b0;
    compare_frame("halt_rel");
    check("halt_rel_frame_cnt", {24'd0, frame_cnt}, 32'd1);

    // Frame counter wrap.
    reset = 1'b0;
    s_reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    for (int k = 0; k < 255; k++) run_frame(1'b0, 20);
    check("wrap_255", {24'd0, frame_cnt}, 32'hFF);
    run_frame(1'b0, 20);
    check("wrap_256", {24'd0, frame_cnt}, 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
